// File: rtl/exec_unit.sv
// Execute/write-back stage in front of a 16x16 register file: reads Ra/Rb, runs one
// ALU op (or a 16-step shift-add multiply), writes the result back to Rb and keeps ZNCV.
module exec_unit #(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          Cmd_valid,
  output logic          Cmd_ready,
  input  logic [3:0]    Cmd_op,
  input  logic [AW-1:0] Cmd_ra,
  input  logic [AW-1:0] Cmd_rb,
  input  logic [W-1:0]  Cmd_imm,
  output logic [AW-1:0] Addr_A,
  output logic [AW-1:0] Addr_B,
  input  logic [W-1:0]  Src,
  input  logic [W-1:0]  Dest,
  output logic [W-1:0]  Data_out,
  output logic          WR,
  output logic [3:0]    Flags,
  output logic          Done,
  output logic          Err
);

  localparam int SW = $clog2(W);
  localparam logic [SW-1:0] CNT_LAST = SW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR = 4'd4,  OP_NOT = 4'd5,  OP_MOV = 4'd6, OP_SHL = 4'd7,
    OP_SHR = 4'd8,  OP_MUL = 4'd9,  OP_CMP = 4'd10, OP_LDI = 4'd11
  } op_e;

  state_e        state;
  logic [3:0]    op;
  logic [W-1:0]  imm;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [W-1:0]  prod_hi;
  logic [W-1:0]  prod_lo;
  logic [SW-1:0] cnt;

  logic [W-1:0]   res;
  logic           c_flag;
  logic           v_flag;
  logic           legal;
  logic [SW-1:0]  sh;
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [W:0]     shl;
  logic [W:0]     shr;
  logic [W:0]     madd;
  logic [2*W-1:0] mul_next;

  assign Cmd_ready = (state == S_IDLE) && RSTn;

  assign sh   = op_a[SW-1:0];
  assign sum  = {1'b0, op_b} + {1'b0, op_a};
  assign diff = {1'b0, op_b} - {1'b0, op_a};
  // The extra bit on each shifter catches the last bit shifted out (0 for a zero shift).
  assign shl  = {1'b0, op_b} << sh;
  assign shr  = {op_b, 1'b0} >> sh;

  // One right-shifting shift-add step: {prod_hi, prod_lo} starts as {0, B}.
  assign madd     = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, op_a} : '0);
  assign mul_next = {madd, prod_lo[W-1:1]};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves a latch.
    res    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    legal  = 1'b1;
    case (op)
      OP_ADD: begin
        res    = sum[W-1:0];
        c_flag = sum[W];
        v_flag = (op_a[W-1] == op_b[W-1]) && (sum[W-1] != op_b[W-1]);
      end
      OP_SUB, OP_CMP: begin
        res    = diff[W-1:0];
        c_flag = diff[W];
        v_flag = (op_a[W-1] != op_b[W-1]) && (diff[W-1] != op_b[W-1]);
      end
      OP_AND: res = op_b & op_a;
      OP_OR:  res = op_b | op_a;
      OP_XOR: res = op_b ^ op_a;
      OP_NOT: res = ~op_a;
      OP_MOV: res = op_a;
      OP_SHL: begin
        res    = shl[W-1:0];
        c_flag = shl[W];
      end
      OP_SHR: begin
        res    = shr[W:1];
        c_flag = shr[0];
      end
      OP_MUL: begin
        res    = mul_next[W-1:0];
        c_flag = |mul_next[2*W-1:W];
      end
      OP_LDI: res = imm;
      default: legal = 1'b0;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state    <= S_IDLE;
      op       <= '0;
      imm      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      prod_hi  <= '0;
      prod_lo  <= '0;
      cnt      <= '0;
      Addr_A   <= '0;
      Addr_B   <= '0;
      Data_out <= '0;
      WR       <= 1'b0;
      Flags    <= '0;
      Done     <= 1'b0;
      Err      <= 1'b0;
    end else begin
      WR   <= 1'b0;
      Done <= 1'b0;
      Err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Cmd_valid) begin
            op     <= Cmd_op;
            imm    <= Cmd_imm;
            Addr_A <= Cmd_ra;
            Addr_B <= Cmd_rb;
            state  <= S_READ;
          end
        end
        S_READ: begin
          op_a    <= Src;
          op_b    <= Dest;
          prod_hi <= '0;
          prod_lo <= Dest;
          cnt     <= '0;
          state   <= S_EXEC;
        end
        S_EXEC: begin
          if (!legal) begin
            Err   <= 1'b1;
            Done  <= 1'b1;
            state <= S_IDLE;
          end else if ((op == OP_MUL) && (cnt != CNT_LAST)) begin
            prod_hi <= mul_next[2*W-1:W];
            prod_lo <= mul_next[W-1:0];
            cnt     <= cnt + 1'b1;
          end else begin
            Flags <= {res == '0, res[W-1], c_flag, v_flag};
            if (op != OP_CMP) begin
              Data_out <= res;
              WR       <= 1'b1;
            end
            Done  <= 1'b1;
            cnt   <= '0;
            state <= S_WB;
          end
        end
        S_WB: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboarded bench for exec_unit: behavioural register file plus an arithmetic
// reference model; a negedge monitor retires expectations on every Done pulse.
module tb_exec_unit;

  localparam int W  = 16;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          Cmd_valid = 1'b0;
  logic          Cmd_ready;
  logic [3:0]    Cmd_op = '0;
  logic [AW-1:0] Cmd_ra = '0;
  logic [AW-1:0] Cmd_rb = '0;
  logic [W-1:0]  Cmd_imm = '0;
  logic [AW-1:0] Addr_A;
  logic [AW-1:0] Addr_B;
  logic [W-1:0]  Src;
  logic [W-1:0]  Dest;
  logic [W-1:0]  Data_out;
  logic          WR;
  logic [3:0]    Flags;
  logic          Done;
  logic          Err;

  exec_unit #(.W(W), .AW(AW)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready), .Cmd_op(Cmd_op),
    .Cmd_ra(Cmd_ra), .Cmd_rb(Cmd_rb), .Cmd_imm(Cmd_imm),
    .Addr_A(Addr_A), .Addr_B(Addr_B), .Src(Src), .Dest(Dest),
    .Data_out(Data_out), .WR(WR), .Flags(Flags), .Done(Done), .Err(Err)
  );

  always #5 CLK = ~CLK;

  // Register file the unit talks to: combinational reads, write on the edge ending WR.
  logic [W-1:0] rf [16] = '{default: '0};
  assign Src  = rf[Addr_A];
  assign Dest = rf[Addr_B];
  always @(posedge CLK) if (WR) rf[Addr_B] <= Data_out;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic       wr;
    logic [3:0] rb;
    logic [15:0] data;
    logic [3:0] flags;
    logic       err;
    int         acc;
    int         lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] ref_r [16] = '{default: '0};
  logic [3:0]  ref_flags = '0;
  bit          ready_busy = 1'b0;
  bit          stray_wr = 1'b0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int sgn(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  // Reference model: result and flags straight from the opcode table, plain integer arithmetic.
  function automatic exp_t model(input int op, input int a, input int b, input int imm,
                                 input logic [3:0] fin);
    exp_t   e;
    int     r;
    int     s;
    longint p;
    bit     c;
    bit     v;
    e.wr = 1'b1; e.err = 1'b0; e.lat = 2; e.rb = '0; e.acc = 0;
    r = 0; c = 1'b0; v = 1'b0;
    case (op)
      0: begin
        r = b + a;
        c = r > 65535;
        v = (sgn(b) + sgn(a) > 32767) || (sgn(b) + sgn(a) < -32768);
      end
      1, 10: begin
        r = b - a;
        c = b < a;
        v = (sgn(b) - sgn(a) > 32767) || (sgn(b) - sgn(a) < -32768);
        if (op == 10) e.wr = 1'b0;
      end
      2: r = b & a;
      3: r = b | a;
      4: r = b ^ a;
      5: r = ~a;
      6: r = a;
      7: begin
        s = a % 16;
        r = b << s;
        c = (s == 0) ? 1'b0 : ((r >> 16) & 1) != 0;
      end
      8: begin
        s = a % 16;
        r = b >> s;
        c = (s == 0) ? 1'b0 : ((b >> (s - 1)) & 1) != 0;
      end
      9: begin
        p = longint'(b) * longint'(a);
        r = int'(p & 64'hFFFF);
        c = (p >> 16) != 0;
        e.lat = 17;
      end
      11: r = imm;
      default: begin
        e.wr  = 1'b0;
        e.err = 1'b1;
      end
    endcase
    r = r & 'hFFFF;
    e.data  = 16'(r);
    e.flags = e.err ? fin : {r == 0, ((r >> 15) & 1) != 0, c, v};
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance with Cmd_valid still high.
  task automatic issue(input int op, input int ra, input int rb, input int imm);
    exp_t e;
    int   n;
    Cmd_op = 4'(op); Cmd_ra = 4'(ra); Cmd_rb = 4'(rb); Cmd_imm = 16'(imm);
    Cmd_valid = 1'b1;
    n = 0;
    while (!Cmd_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!Cmd_ready) begin
      n_total++;
      $display("FAIL accept_timeout: Cmd_ready low for %0d cycles, expected high", n);
      Cmd_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    e = model(op, int'(ref_r[ra]), int'(ref_r[rb]), imm, ref_flags);
    e.rb  = 4'(rb);
    e.acc = cyc;
    if (e.wr) ref_r[rb] = e.data;
    ref_flags = e.flags;
    sb.push_back(e);
    @(negedge CLK);
  endtask

  task automatic drain();
    int n;
    Cmd_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("drain_pending", 32'(sb.size()), 0);
  endtask

  always @(negedge CLK) begin
    if (RSTn) begin
      if (WR && !Done) stray_wr = 1'b1;
      if (sb.size() != 0 && Cmd_ready && !Done) ready_busy = 1'b1;
      if (Done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'(Done), 0);
        end else begin
          mon_e = sb.pop_front();
          check("done_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
          check("wr", 32'(WR), 32'(mon_e.wr));
          check("err", 32'(Err), 32'(mon_e.err));
          check("flags", 32'(Flags), 32'(mon_e.flags));
          check("ready_while_busy", 32'(ready_busy), 0);
          if (mon_e.wr) begin
            check("wr_addr", 32'(Addr_B), 32'(mon_e.rb));
            check("wr_data", 32'(Data_out), 32'(mon_e.data));
          end
          ready_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc;
    int op;
    int ra;
    int rb;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready", 32'(Cmd_ready), 0);
    check("rst_wr", 32'(WR), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_err", 32'(Err), 0);
    check("rst_flags", 32'(Flags), 0);
    check("rst_addr_a", 32'(Addr_A), 0);
    check("rst_addr_b", 32'(Addr_B), 0);
    check("rst_data_out", 32'(Data_out), 0);
    RSTn = 1'b1;
    @(negedge CLK);

    issue(11, 0, 1, 'h1234);
    issue(11, 0, 7, 'h5678);
    issue(0, 1, 7, 0);
    issue(6, 7, 4, 0);
    issue(11, 0, 2, 'h7FFF);
    issue(11, 0, 3, 'h0001);
    issue(0, 3, 2, 0);
    issue(1, 1, 1, 0);
    issue(10, 7, 3, 0);
    issue(11, 0, 5, 'h0100);
    issue(11, 0, 6, 'h0100);
    issue(9, 5, 6, 0);
    issue(13, 0, 0, 0);
    issue(11, 0, 8, 'h00AA);
    drain();
    check("r7_add", 32'(rf[7]), 'h68AC);
    check("r4_mov", 32'(rf[4]), 'h68AC);
    check("r2_ovf", 32'(rf[2]), 'h8000);
    check("r1_sub", 32'(rf[1]), 'h0000);
    check("r6_mul", 32'(rf[6]), 'h0000);

    // Reset during the eighth multiplier cycle: the command must vanish without a write.
    @(negedge CLK);
    Cmd_op = 4'd9; Cmd_ra = 4'd2; Cmd_rb = 4'd3; Cmd_valid = 1'b1;
    @(posedge CLK);
    #1;
    acc = cyc;
    @(negedge CLK);
    Cmd_valid = 1'b0;
    check("abort_accepted", 32'(Cmd_ready), 0);
    while (cyc < acc + 8) @(negedge CLK);
    RSTn = 1'b0;
    @(negedge CLK);
    check("abort_wr", 32'(WR), 0);
    check("abort_done", 32'(Done), 0);
    check("abort_flags", 32'(Flags), 0);
    check("abort_addr_a", 32'(Addr_A), 0);
    check("abort_addr_b", 32'(Addr_B), 0);
    check("abort_ready", 32'(Cmd_ready), 0);
    RSTn = 1'b1;
    ref_flags = '0;
    repeat (20) @(negedge CLK);
    check("abort_r3_kept", 32'(rf[3]), 32'(ref_r[3]));
    issue(11, 0, 9, 'hBEEF);
    drain();

    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = 11;
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) ra = rb;
      issue(op, ra, rb, int'($urandom_range(0, 65535)));
    end
    drain();

    check("stray_wr", 32'(stray_wr), 0);
    for (int i = 0; i < 16; i++) check($sformatf("rf_final[%0d]", i), 32'(rf[i]), 32'(ref_r[i]));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
